ps2_note_decoder: RTL and testbench

// - Consumes PS/2 Set-2 scan-code bytes from the serial receiver stage and turns them into piano key state.
// - Tracks make/break/extended prefixes and keeps a 13-key held bitmap for C4..C5.
// - Produces the active note (lowest held key) and one-cycle key events for the tone generator downstream.
// - Single clock domain; the byte arrives already synchronised with a one-cycle valid strobe.

---
 rtl/ps2_note_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_ps2_note_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_note_decoder.sv
// PS/2 Set-2 scan-code decoder for a 13-key piano (C4..C5).
// Tracks the make/break/extended prefix sequence and maintains a held-key
// bitmap. Outputs the lowest held note and one-cycle press/release events.
// A prefix byte that is not followed by another byte within TIMEOUT_CYC
// cycles is abandoned.
module ps2_note_decoder #(
    parameter int TIMEOUT_CYC = 2_500_000,
    parameter int CNT_W       = 22
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        code_valid,
    input  logic [7:0]  code,
    output logic [12:0] key_held,
    output logic [3:0]  note,
    output logic        note_valid,
    output logic        key_event,
    output logic [3:0]  event_note,
    output logic        event_make
);

    localparam logic [7:0] C_BREAK  = 8'hF0;
    localparam logic [7:0] C_EXTEND = 8'hE0;
    localparam logic [7:0] C_OVR_LO = 8'h00;
    localparam logic [7:0] C_OVR_HI = 8'hFF;
    localparam logic [7:0] C_BAT_OK = 8'hAA;

    // Last counter value before a pending prefix is abandoned
    localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BRK     = 2'd1,
        S_EXT     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Make code to note lookup; result is {hit, note index}
    function automatic logic [4:0] map_code(input logic [7:0] c);
        case (c)
            8'h1C:   map_code = {1'b1, 4'd0};
            8'h1D:   map_code = {1'b1, 4'd1};
            8'h1B:   map_code = {1'b1, 4'd2};
            8'h24:   map_code = {1'b1, 4'd3};
            8'h23:   map_code = {1'b1, 4'd4};
            8'h2B:   map_code = {1'b1, 4'd5};
            8'h2C:   map_code = {1'b1, 4'd6};
            8'h34:   map_code = {1'b1, 4'd7};
            8'h35:   map_code = {1'b1, 4'd8};
            8'h33:   map_code = {1'b1, 4'd9};
            8'h3C:   map_code = {1'b1, 4'd10};
            8'h3B:   map_code = {1'b1, 4'd11};
            8'h42:   map_code = {1'b1, 4'd12};
            default: map_code = 5'd0;
        endcase
    endfunction

    // Bytes that signal the keyboard lost its state; all keys are dropped
    function automatic logic is_flush_code(input logic [7:0] c);
        is_flush_code = (c == C_OVR_LO) || (c == C_OVR_HI) || (c == C_BAT_OK);
    endfunction

    // Priority encoder: index of the lowest set bit, 0 when empty
    function automatic logic [3:0] lowest_index(input logic [12:0] k);
        lowest_index = 4'd0;
        for (int i = 12; i >= 0; i--) begin
            if (k[i]) begin
                lowest_index = 4'(i);
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic [12:0]      r_key_held;
    logic [3:0]       r_note;
    logic             r_note_valid;
    logic             r_key_event;
    logic [3:0]       r_event_note;
    logic             r_event_make;

    // ------------------------------------------------------------------
    // Byte decode
    // ------------------------------------------------------------------
    logic [4:0]  w_map;
    logic        w_hit;
    logic [3:0]  w_idx;
    logic [12:0] w_onehot;
    logic        w_flush;
    logic        w_make;
    logic        w_break;
    logic        w_event;
    logic [12:0] w_held_nxt;

    assign w_map    = map_code(code);
    assign w_hit    = w_map[4];
    assign w_idx    = w_map[3:0];
    assign w_onehot = 13'd1 << w_idx;
    assign w_flush  = code_valid && is_flush_code(code);

    // A make only counts from IDLE and only when the key is not already
    // held, so typematic repeats are silent. A break only counts after F0
    // and only when the key is actually held.
    assign w_make  = code_valid && !w_flush && (r_state == S_IDLE) &&
                     w_hit && ((r_key_held & w_onehot) == 13'd0);
    assign w_break = code_valid && !w_flush && (r_state == S_BRK) &&
                     w_hit && ((r_key_held & w_onehot) != 13'd0);
    assign w_event = w_make || w_break;

    // Next held bitmap from the decoded action
    always_comb begin
        w_held_nxt = r_key_held;
        if (w_flush) begin
            w_held_nxt = 13'd0;
        end else if (w_make) begin
            w_held_nxt = r_key_held | w_onehot;
        end else if (w_break) begin
            w_held_nxt = r_key_held & ~w_onehot;
        end
    end

    // ------------------------------------------------------------------
    // Prefix FSM with inter-byte timeout
    // ------------------------------------------------------------------

    // Sequence tracker: a received byte always wins over the timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tmo_cnt <= '0;
        end else if (code_valid) begin
            r_tmo_cnt <= '0;
            if (is_flush_code(code)) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (code == C_BREAK) begin
                            r_state <= S_BRK;
                        end else if (code == C_EXTEND) begin
                            r_state <= S_EXT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_EXT: begin
                        if (code == C_BREAK) begin
                            r_state <= S_EXT_BRK;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end else if (r_state != S_IDLE) begin
            if (r_tmo_cnt == C_TMO_LAST) begin
                r_state   <= S_IDLE;
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
            end
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Key state and event outputs
    // ------------------------------------------------------------------

    // Register held map, derived note and the one-cycle change event
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_held   <= 13'd0;
            r_note       <= 4'd0;
            r_note_valid <= 1'b0;
            r_key_event  <= 1'b0;
            r_event_note <= 4'd0;
            r_event_make <= 1'b0;
        end else begin
            r_key_held   <= w_held_nxt;
            r_note       <= lowest_index(w_held_nxt);
            r_note_valid <= |w_held_nxt;
            r_key_event  <= w_event;
            if (w_event) begin
                r_event_note <= w_idx;
                r_event_make <= w_make;
            end
        end
    end

    assign key_held   = r_key_held;
    assign note       = r_note;
    assign note_valid = r_note_valid;
    assign key_event  = r_key_event;
    assign event_note = r_event_note;
    assign event_make = r_event_make;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Bench for ps2_note_decoder: directed scenarios followed by randomized
// byte streams compared against a behavioural model of key state.
module tb_ps2_note_decoder;

    localparam int T     = 16;
    localparam int CNT_W = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        code_valid;
    logic [7:0]  code;
    logic [12:0] key_held;
    logic [3:0]  note;
    logic        note_valid;
    logic        key_event;
    logic [3:0]  event_note;
    logic        event_make;

    always #5 clk = ~clk;

    ps2_note_decoder #(.TIMEOUT_CYC(T), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .code       (code),
        .key_held   (key_held),
        .note       (note),
        .note_valid (note_valid),
        .key_event  (key_event),
        .event_note (event_note),
        .event_make (event_make)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Key table in note order
    logic [7:0] key_codes [13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                                   8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};

    // Model: held set, pending prefix (0 none, 1 F0, 2 E0, 3 E0 F0),
    // edge index of the last accepted byte, current edge index
    logic [12:0] m_held;
    int          m_prefix;
    longint      m_last;
    longint      cyc;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    function automatic int note_of(input logic [7:0] b);
        for (int i = 0; i < 13; i++) begin
            if (key_codes[i] == b) return i;
        end
        return -1;
    endfunction

    function automatic int lowest_of(input logic [12:0] k);
        for (int i = 0; i < 13; i++) begin
            if (k[i]) return i;
        end
        return 0;
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".held"},  32'(key_held),   32'(m_held));
        check({tag, ".note"},  32'(note),       32'(lowest_of(m_held)));
        check({tag, ".nvld"},  32'(note_valid), 32'(m_held != 13'd0));
    endtask

    // Present one byte for one cycle and compare against the model
    task automatic send(input logic [7:0] b, input string tag);
        int  n;
        int  pfx;
        bit  ev;
        bit  mk;
        code_valid = 1'b1;
        code       = b;
        @(posedge clk);
        cyc++;
        #1;
        code_valid = 1'b0;
        pfx = m_prefix;
        if (pfx != 0 && (cyc - m_last) > T) pfx = 0;
        n  = note_of(b);
        ev = 1'b0;
        mk = 1'b0;
        if (b == 8'h00 || b == 8'hFF || b == 8'hAA) begin
            m_held = 13'd0;
            pfx    = 0;
        end else begin
            case (pfx)
                0: begin
                    if (b == 8'hF0) pfx = 1;
                    else if (b == 8'hE0) pfx = 2;
                    else if (n >= 0 && !m_held[n]) begin
                        m_held[n] = 1'b1;
                        ev = 1'b1;
                        mk = 1'b1;
                    end
                end
                1: begin
                    if (n >= 0 && m_held[n]) begin
                        m_held[n] = 1'b0;
                        ev = 1'b1;
                    end
                    pfx = 0;
                end
                2: pfx = (b == 8'hF0) ? 3 : 0;
                default: pfx = 0;
            endcase
        end
        m_prefix = pfx;
        m_last   = cyc;
        check_state(tag);
        check({tag, ".evt"}, 32'(key_event), 32'(ev));
        if (ev) begin
            check({tag, ".enote"}, 32'(event_note), 32'(n));
            check({tag, ".emake"}, 32'(event_make), 32'(mk));
        end
    endtask

    // Idle cycles: nothing may change and no event may fire
    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            check({tag, ".idle_evt"},  32'(key_event), 32'(0));
            check({tag, ".idle_held"}, 32'(key_held),  32'(m_held));
        end
    endtask

    // One reset cycle, optionally with a byte strobed in the same cycle
    task automatic do_reset(input bit with_byte, input string tag);
        reset      = 1'b1;
        code_valid = with_byte;
        code       = 8'h1C;
        @(posedge clk);
        cyc++;
        #1;
        reset      = 1'b0;
        code_valid = 1'b0;
        m_held     = 13'd0;
        m_prefix   = 0;
        m_last     = cyc;
        check_state(tag);
        check({tag, ".evt"},   32'(key_event),  32'(0));
        check({tag, ".enote"}, 32'(event_note), 32'(0));
        check({tag, ".emake"}, 32'(event_make), 32'(0));
    endtask

    initial begin
        int gaps [9] = '{0, 0, 0, 1, 2, T - 2, T - 1, T, T + 1};
        reset      = 1'b1;
        code_valid = 1'b0;
        code       = 8'h00;
        cyc        = 0;
        m_held     = 13'd0;
        m_prefix   = 0;
        m_last     = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b1, "reset");

        // Single press
        send(8'h1C, "press_c4");
        // Second key, then release the first
        send(8'h42, "press_c5");
        send(8'hF0, "rel_pfx");
        send(8'h1C, "rel_c4");
        check("rel_c4.held_abs", 32'(key_held), 32'h1000);
        check("rel_c4.note_abs", 32'(note), 32'd12);
        send(8'hF0, "rel2_pfx");
        send(8'h42, "rel_c5");

        // Typematic repeat
        send(8'h1C, "typ1");
        send(8'h1C, "typ2");
        idle(1, "typ_gap");
        send(8'h1C, "typ3");

        // Extended sequences have no effect and leave FSM idle
        send(8'hE0, "ext");
        send(8'h1C, "ext_1c");
        send(8'hE0, "extb_e0");
        send(8'hF0, "extb_f0");
        send(8'h1C, "extb_1c");
        send(8'h1D, "after_ext");

        // Timeout: prefix abandoned, next byte is a make
        send(8'hAA, "bat1");
        send(8'hF0, "tmo_pfx");
        idle(T, "tmo_wait");
        send(8'h1C, "tmo_make");
        check("tmo_make.abs", 32'(event_make), 32'd1);

        // Byte on the last counter cycle still sees the prefix
        send(8'hF0, "tmo_edge_pfx");
        idle(T - 1, "tmo_edge_wait");
        send(8'h1C, "tmo_edge_brk");

        // BAT flush
        send(8'h1D, "hold_1d");
        send(8'h23, "hold_23");
        send(8'hAA, "bat_flush");
        check("bat_flush.nvld_abs", 32'(note_valid), 32'd0);

        // Reset mid-sequence
        send(8'hF0, "rst_pfx");
        do_reset(1'b0, "rst_mid");
        send(8'h1C, "rst_make");

        // Randomized streams
        for (int it = 0; it < 600; it++) begin
            int r;
            int r2;
            logic [7:0] b;
            r  = $urandom_range(0, 99);
            r2 = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset(r2[0], "rnd_rst");
            end else begin
                if (r2 < 50)      b = key_codes[$urandom_range(0, 12)];
                else if (r2 < 65) b = 8'hF0;
                else if (r2 < 75) b = 8'hE0;
                else if (r2 < 78) b = (r2 == 75) ? 8'h00 : ((r2 == 76) ? 8'hFF : 8'hAA);
                else if (r2 < 85) b = (r2 < 80) ? 8'hFA : ((r2 < 82) ? 8'hEE : 8'hFE);
                else              b = 8'($urandom_range(0, 255));
                send(b, "rnd");
                idle(gaps[$urandom_range(0, 8)], "rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
